// File: rtl/cmd_fe_pkg.sv
// Shared constants, command codes and state encoding for the command front end.
// CMD_FE_CHECKSUM_EN adds the CSUM header state.
package cmd_fe_pkg;

    localparam logic [7:0] SYNC_BYTE    = 8'h55;

    localparam logic [7:0] CMD_LOOP     = 8'h01;
    localparam logic [7:0] CMD_SD_INIT  = 8'h02;
    localparam logic [7:0] CMD_SD_RD    = 8'h03;
    localparam logic [7:0] CMD_SD_WR    = 8'h04;
    localparam logic [7:0] CMD_SET_FIFO = 8'h06;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_CMD  = 2'd1;
    localparam logic [1:0] ERR_CSUM     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN_H,
        ST_LEN_L,
`ifdef CMD_FE_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_ISSUE,
        ST_BUSY,
        ST_ACK,
        ST_ERR
    } fe_state_t;

    function automatic logic is_valid_cmd(input logic [7:0] code);
        return (code == CMD_LOOP)  || (code == CMD_SD_INIT) || (code == CMD_SD_RD) ||
               (code == CMD_SD_WR) || (code == CMD_SET_FIFO);
    endfunction

endpackage

// File: rtl/cmd_fe_timer.sv
// Clearable idle counter; tc fires on the cycle that would complete TIMEOUT_CYC idle cycles.
module cmd_fe_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] count;

    assign tc = en && !clr && (count == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !en || clr || tc) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/cmd_frontend.sv
// UART command-frame decoder: SYNC, CMD, LEN_H, LEN_L [, CSUM] then issue/ack handshake.
// Define CMD_FE_CHECKSUM_EN to carry and check the CSUM byte.
module cmd_frontend
    import cmd_fe_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FE_HOLD     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        fifo_busy,
    input  logic        fifo_done,
    output logic [7:0]  cmd,
    output logic [15:0] rx_cnt,
    output logic        en_fc,
    output logic        fe_done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int HW = $clog2(FE_HOLD + 1);

    fe_state_t     state;
    logic [HW-1:0] hold_cnt;
    logic          hdr_state;
    logic          tmo_hit;

    always_comb begin
        hdr_state = (state == ST_CMD) || (state == ST_LEN_H) || (state == ST_LEN_L);
`ifdef CMD_FE_CHECKSUM_EN
        hdr_state = hdr_state || (state == ST_CSUM);
`endif
    end

    cmd_fe_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (hdr_state),
        .clr (rx_valid),
        .tc  (tmo_hit)
    );

    // A received byte always takes priority over a timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmd      <= '0;
            rx_cnt   <= '0;
            en_fc    <= 1'b0;
            fe_done  <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            hold_cnt <= '0;
        end else begin
            en_fc <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state    <= ST_CMD;
                        err_code <= ERR_NONE;
                    end
                end
                ST_CMD: begin
                    if (rx_valid) begin
                        if (is_valid_cmd(rx_data)) begin
                            cmd   <= rx_data;
                            state <= ST_LEN_H;
                        end else begin
                            state    <= ST_ERR;
                            err      <= 1'b1;
                            err_code <= ERR_BAD_CMD;
                        end
                    end else if (tmo_hit) begin
                        state    <= ST_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_LEN_H: begin
                    if (rx_valid) begin
                        rx_cnt[15:8] <= rx_data;
                        state        <= ST_LEN_L;
                    end else if (tmo_hit) begin
                        state    <= ST_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_LEN_L: begin
                    if (rx_valid) begin
                        rx_cnt[7:0] <= rx_data;
`ifdef CMD_FE_CHECKSUM_EN
                        state       <= ST_CSUM;
`else
                        state       <= ST_ISSUE;
`endif
                    end else if (tmo_hit) begin
                        state    <= ST_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
`ifdef CMD_FE_CHECKSUM_EN
                ST_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == (cmd ^ rx_cnt[15:8] ^ rx_cnt[7:0])) begin
                            state <= ST_ISSUE;
                        end else begin
                            state    <= ST_ERR;
                            err      <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end else if (tmo_hit) begin
                        state    <= ST_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
`endif
                ST_ISSUE: begin
                    if (!fifo_busy) begin
                        en_fc <= 1'b1;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (fifo_done) begin
                        state    <= ST_ACK;
                        fe_done  <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                // fe_done stays high FE_HOLD cycles; the controller keys off its falling edge.
                ST_ACK: begin
                    if (fe_done) begin
                        if (hold_cnt == HW'(FE_HOLD - 1)) begin
                            fe_done <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end else if (!fifo_busy) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_frontend.sv
// Directed, table-driven bench for cmd_frontend; expectations follow CMD_FE_CHECKSUM_EN.
module tb_cmd_frontend;

    localparam int TMO  = 50000;
    localparam int HOLD = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        fifo_busy;
    logic        fifo_done;
    logic [7:0]  cmd;
    logic [15:0] rx_cnt;
    logic        en_fc;
    logic        fe_done;
    logic        err;
    logic [1:0]  err_code;

    int compared   = 0;
    int mismatched = 0;

    int          en_tot  = 0;
    int          err_tot = 0;
    int          fe_tot  = 0;
    logic [7:0]  cap_cmd = '0;
    logic [15:0] cap_cnt = '0;
    logic [1:0]  cap_code = '0;

    typedef struct {
        string       name;
        logic [47:0] bytes;
        int          n;
        bit          exp_en;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_cnt;
        bit          exp_err;
        logic [1:0]  exp_code;
    } frame_t;

    frame_t vec [7];

    cmd_frontend #(
        .TIMEOUT_CYC(TMO),
        .FE_HOLD    (HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .fifo_busy(fifo_busy),
        .fifo_done(fifo_done),
        .cmd      (cmd),
        .rx_cnt   (rx_cnt),
        .en_fc    (en_fc),
        .fe_done  (fe_done),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (en_fc) begin
            en_tot  <= en_tot + 1;
            cap_cmd <= cmd;
            cap_cnt <= rx_cnt;
        end
        if (err) begin
            err_tot  <= err_tot + 1;
            cap_code <= err_code;
        end
        if (fe_done) fe_tot <= fe_tot + 1;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        waitCycles(1);
        rx_valid = 1'b0;
        waitCycles(gap);
    endtask

    task automatic pulseDone();
        fifo_done = 1'b1;
        waitCycles(1);
        fifo_done = 1'b0;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " outputs"}, {6'd0, cmd, rx_cnt}, 32'd0);
        checkOutput({name, " flags"}, {27'd0, en_fc, fe_done, err, err_code}, 32'd0);
    endtask

    task automatic applyStimulus(input frame_t f);
        int en0, err0, fe0;
        en0  = en_tot;
        err0 = err_tot;
        for (int k = 0; k < f.n; k++) sendByte(f.bytes[47-8*k -: 8], 2);
        waitCycles(4);
        checkOutput({f.name, " en_fc pulses"}, en_tot - en0, {31'd0, f.exp_en});
        checkOutput({f.name, " err pulses"}, err_tot - err0, {31'd0, f.exp_err});
        if (f.exp_en) begin
            checkOutput({f.name, " cmd"}, cap_cmd, f.exp_cmd);
            checkOutput({f.name, " rx_cnt"}, cap_cnt, f.exp_cnt);
            fe0 = fe_tot;
            pulseDone();
            waitCycles(10);
            checkOutput({f.name, " fe_done cycles"}, fe_tot - fe0, HOLD);
        end
        if (f.exp_err) checkOutput({f.name, " err_code"}, cap_code, f.exp_code);
    endtask

    initial begin
        int n, en0, err0;
        frame_t f;

        vec[0] = '{"loop",     48'h55_01_00_04_05_00, 5, 1'b1, 8'h01, 16'h0004, 1'b0, 2'd0};
        vec[1] = '{"badcmd",   48'h55_07_00_00_07_00, 5, 1'b0, 8'h00, 16'h0000, 1'b1, 2'd1};
`ifdef CMD_FE_CHECKSUM_EN
        vec[2] = '{"csum",     48'h55_02_00_10_00_00, 5, 1'b0, 8'h00, 16'h0000, 1'b1, 2'd2};
`else
        vec[2] = '{"csum",     48'h55_02_00_10_00_00, 5, 1'b1, 8'h02, 16'h0010, 1'b0, 2'd0};
`endif
        vec[3] = '{"zerolen",  48'h55_04_00_00_04_00, 5, 1'b1, 8'h04, 16'h0000, 1'b0, 2'd0};
        vec[4] = '{"syncascmd",48'h55_55_00_00_00_00, 5, 1'b0, 8'h00, 16'h0000, 1'b1, 2'd1};
        vec[5] = '{"garbage",  48'hAA_55_06_12_34_20, 6, 1'b1, 8'h06, 16'h1234, 1'b0, 2'd0};
        vec[6] = '{"wide",     48'h55_03_AB_CD_65_00, 5, 1'b1, 8'h03, 16'hABCD, 1'b0, 2'd0};

        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; fifo_busy = 1'b0; fifo_done = 1'b0;
        @(posedge clk); #2;
        waitCycles(2);
        checkAllZero("reset");
        rst = 1'b0;
        waitCycles(2);

        for (int i = 0; i < 7; i++) applyStimulus(vec[i]);

        // Latency: en_fc visible after the second edge following the last header byte.
        sendByte(8'h55, 0); sendByte(8'h01, 0); sendByte(8'h00, 0);
`ifdef CMD_FE_CHECKSUM_EN
        sendByte(8'h04, 0);
        sendByte(8'h05, 0);
`else
        sendByte(8'h04, 0);
`endif
        @(negedge clk); checkOutput("latency edge+1", en_fc, 1'b0);
        @(negedge clk); checkOutput("latency edge+2", en_fc, 1'b1);
        @(negedge clk); checkOutput("latency edge+3", en_fc, 1'b0);
        @(posedge clk); #2;
        pulseDone();
        waitCycles(10);

        fifo_busy = 1'b1;
        en0 = en_tot;
        sendByte(8'h55, 2); sendByte(8'h06, 2); sendByte(8'h00, 2);
        sendByte(8'h02, 2); sendByte(8'h04, 2);
        waitCycles(6);
        checkOutput("busy hold en_fc", en_tot - en0, 0);
        fifo_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy release en_fc", en_fc, 1'b1);
        checkOutput("busy release cmd", cmd, 8'h06);
        checkOutput("busy release rx_cnt", rx_cnt, 16'h0002);
        @(posedge clk); #2;
        pulseDone();
        waitCycles(10);

        en0 = en_tot; err0 = err_tot;
        sendByte(8'h55, 0); sendByte(8'h07, 0); sendByte(8'h55, 0);
        sendByte(8'h01, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h01, 0);
        waitCycles(6);
        checkOutput("err drop en_fc", en_tot - en0, 0);
        checkOutput("err drop err", err_tot - err0, 1);

        sendByte(8'h55, 0); sendByte(8'h03, 0);
        n = 0;
        while (n < TMO + 100) begin
            @(negedge clk);
            n++;
            if (err) break;
        end
        checkOutput("timeout cycles", n, TMO + 1);
        checkOutput("timeout err_code", err_code, 2'd3);
        @(posedge clk); #2;
        waitCycles(2);
        f = '{"after timeout", 48'h55_04_00_00_04_00, 5, 1'b1, 8'h04, 16'h0000, 1'b0, 2'd0};
        applyStimulus(f);

        sendByte(8'h55, 2); sendByte(8'h01, 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("reset in LEN_H");
        @(posedge clk); #2;
        rst = 1'b0;
        f = '{"after rst LEN_H", 48'h55_02_00_03_01_00, 5, 1'b1, 8'h02, 16'h0003, 1'b0, 2'd0};
        applyStimulus(f);

        sendByte(8'h55, 2); sendByte(8'h01, 2); sendByte(8'h00, 2);
        sendByte(8'h01, 2); sendByte(8'h00, 2);
        waitCycles(2);
        pulseDone();
        waitCycles(1);
        checkOutput("ack before reset", fe_done, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("reset in ACK");
        @(posedge clk); #2;
        rst = 1'b0;
        f = '{"after rst ACK", 48'h55_06_01_00_07_00, 5, 1'b1, 8'h06, 16'h0100, 1'b0, 2'd0};
        applyStimulus(f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
